seq_order_monitor: RTL and testbench
====================================

// Module: seq_order_monitor
// PURPOSE
//  Synthesisable checker for an ordered event chain e[s0] ##[1:MAX_GAP] e[s1] ... e[s(L-1)],
//  sampled on posedge sysclk. It generalises fixed-length, fixed-##1 protocol sequences
//  (e.g. trans, start, a, b, c, end) in step count, event width, gap window and strictness.
//  It sits beside bus/transaction logic and reports match/fail pulses and saturating counts.
// PARAMETERS
//  NUM_EV   6  number of event inputs
//  DEPTH    6  max steps per sequence
//  MAX_GAP  1  max cycles from one step to the next (1 = pure ##1 chain); >=1
//  STRICT   0  1: a wrong sequence event while waiting aborts with fail
//  CNT_W    16 width of match/fail counters
//  (derived) IDX_W = clog2(NUM_EV), LEN_W = clog2(DEPTH+1), GAP_W = clog2(MAX_GAP+1)
// PORTS
//  sysclk      in  1             clock, all logic on posedge
//  rst_n       in  1             asynchronous active-low reset
//  enable      in  1             0: abort any attempt silently, hold IDLE
//  clear       in  1             synchronous clear of match_cnt/fail_cnt
//  ev          in  NUM_EV        event strobes, sampled each posedge
//  cfg_len     in  LEN_W         sequence length L; 0 = detection off; >DEPTH treated as DEPTH
//  cfg_step_ev in  DEPTH*IDX_W   event index for step k in bits [k*IDX_W +: IDX_W]
//  match       out 1             1-cycle pulse: full chain completed
//  fail        out 1             1-cycle pulse: attempt aborted (timeout / STRICT violation)
//  busy        out 1             attempt in progress (state ARMED)
//  cur_step    out LEN_W         next expected step index (0 when IDLE)
//  match_cnt   out CNT_W         saturating match count
//  fail_cnt    out CNT_W         saturating fail count
// BEHAVIOUR
//  - Reset: state IDLE; match=fail=busy=0; cur_step=0; counters=0; shadow cfg=0.
//  - Single-thread, non-overlapping: at most one attempt tracked.
//  - IDLE: if enable && L>=1 && ev[cfg_step_ev[0]] -> capture cfg_len/cfg_step_ev into shadow
//    regs; if L==1 pulse match next cycle, stay IDLE; else ARMED, cur_step=1, gap=0.
//  - ARMED (waiting step k, shadow cfg used): each cycle gap+=1.
//    * ev[sel[k]]=1 -> if k==L-1: match pulse, IDLE; else cur_step=k+1, gap=0.
//    * else STRICT && any ev[sel[j]] (j<L, sel[j]!=sel[k]) =1 -> fail pulse, IDLE.
//    * else gap reaches MAX_GAP -> fail pulse, IDLE (timeout).
//  - Expected event takes priority over STRICT violation and timeout in the same cycle.
//  - match/fail registered: asserted the cycle after the deciding edge, low otherwise;
//    never both high.
//  - Cycle that ends an attempt (match or fail) does not start a new one even if ev[sel[0]]=1;
//    new attempt evaluated from the following edge.
//  - enable=0: state->IDLE, cur_step=0, no fail pulse; counters hold.
//  - Counters: +1 on each match/fail pulse, saturate at 2^CNT_W-1; clear wins over increment.
//  - cfg_* changes while ARMED have no effect until next attempt start.
//  - Async reset mid-attempt: immediate return to reset values, no pulse.
// TESTING (defaults; sel = 0,1,2,3,4,5; L=6)
//  - ev one-hot 0,1,2,3,4,5 on 6 consecutive cycles -> match=1 one cycle after ev[5], match_cnt=1.
//  - Same but one idle cycle after ev[2] -> fail pulse at gap timeout, fail_cnt=1, busy=0.
//  - MAX_GAP=3, two idle cycles between every step -> match; three idle cycles -> fail.
//  - STRICT=1, ev[3] while expecting step 2 -> fail; STRICT=0 same stimulus -> attempt continues.
//  - enable dropped at cur_step=4 -> busy=0, no fail, counters unchanged; rst_n low mid-run -> all 0.
//  - CNT_W=2, 5 matches -> match_cnt=3 (saturates); clear with match same cycle -> 0.

Source files
------------

// File: rtl/seq_order_monitor.sv
// seq_order_monitor: watches for the ordered event chain sel[0] ##[1:MAX_GAP] sel[1] ...
// sel[L-1] and reports 1-cycle match/fail pulses plus saturating match/fail counts.
// Only one attempt is tracked at a time; the step table and length are captured when an
// attempt starts, so reprogramming mid-attempt only affects the next one.
//
// state | meaning
// IDLE  | no attempt in progress; watching for the first step event
// ARMED | attempt in progress; waiting for step cur_step within the gap window
module seq_order_monitor #(
    parameter int  NUM_EV  = 6,
    parameter int  DEPTH   = 6,
    parameter int  MAX_GAP = 1,
    parameter int  STRICT  = 0,
    parameter int  CNT_W   = 16,
    localparam int IDX_W   = (NUM_EV > 1) ? $clog2(NUM_EV) : 1,
    localparam int LEN_W   = $clog2(DEPTH + 1),
    localparam int GAP_W   = $clog2(MAX_GAP + 1)
) (
    input  logic                   sysclk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   clear,
    input  logic [NUM_EV-1:0]      ev,
    input  logic [LEN_W-1:0]       cfg_len,
    input  logic [DEPTH*IDX_W-1:0] cfg_step_ev,
    output logic                   match,
    output logic                   fail,
    output logic                   busy,
    output logic [LEN_W-1:0]       cur_step,
    output logic [CNT_W-1:0]       match_cnt,
    output logic [CNT_W-1:0]       fail_cnt
);

    typedef enum logic {IDLE, ARMED} state_t;

    state_t                 state_q, state_d;
    logic [LEN_W-1:0]       step_q, step_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [DEPTH*IDX_W-1:0] sel_q, sel_d;
    logic                   match_q, match_d;
    logic                   fail_q, fail_d;
    logic [CNT_W-1:0]       match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0]       fail_cnt_q, fail_cnt_d;

    // ev is padded to the full index range so an out-of-range selector simply never fires
    logic [(1<<IDX_W)-1:0]  ev_pad;
    logic [LEN_W-1:0]       len_clamp;
    logic [IDX_W-1:0]       cur_idx;
    logic [GAP_W-1:0]       gap_inc;
    logic                   strict_viol;

    // Decode selected events: current step's event and any other in-sequence event firing
    always_comb begin
        ev_pad             = '0;
        ev_pad[NUM_EV-1:0] = ev;
        len_clamp          = (cfg_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : cfg_len;
        gap_inc            = gap_q + GAP_W'(1);
        cur_idx            = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (step_q == LEN_W'(k)) begin
                cur_idx = sel_q[k*IDX_W +: IDX_W];
            end
        end
        strict_viol = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            if ((LEN_W'(j) < len_q) && (sel_q[j*IDX_W +: IDX_W] != cur_idx)
                && ev_pad[sel_q[j*IDX_W +: IDX_W]]) begin
                strict_viol = 1'b1;
            end
        end
    end

    // Next-state logic: attempt start, step advance, strict abort, gap timeout, counters
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        gap_d   = gap_q;
        len_d   = len_q;
        sel_d   = sel_q;
        match_d = 1'b0;
        fail_d  = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            step_d  = '0;
            gap_d   = '0;
        end else if (state_q == IDLE) begin
            if ((len_clamp != '0) && ev_pad[cfg_step_ev[IDX_W-1:0]]) begin
                len_d = len_clamp;
                sel_d = cfg_step_ev;
                if (len_clamp == LEN_W'(1)) begin
                    match_d = 1'b1;
                end else begin
                    state_d = ARMED;
                    step_d  = LEN_W'(1);
                    gap_d   = '0;
                end
            end
        end else begin
            // expected event wins over a strict violation or timeout in the same cycle
            if (ev_pad[cur_idx]) begin
                gap_d = '0;
                if (step_q == len_q - LEN_W'(1)) begin
                    match_d = 1'b1;
                    state_d = IDLE;
                    step_d  = '0;
                end else begin
                    step_d = step_q + LEN_W'(1);
                end
            end else if ((STRICT != 0) && strict_viol) begin
                fail_d  = 1'b1;
                state_d = IDLE;
                step_d  = '0;
                gap_d   = '0;
            end else if (gap_inc == GAP_W'(MAX_GAP)) begin
                fail_d  = 1'b1;
                state_d = IDLE;
                step_d  = '0;
                gap_d   = '0;
            end else begin
                gap_d = gap_inc;
            end
        end

        // counters move together with the registered pulse; clear beats increment
        match_cnt_d = match_cnt_q;
        fail_cnt_d  = fail_cnt_q;
        if (clear) begin
            match_cnt_d = '0;
            fail_cnt_d  = '0;
        end else begin
            if (match_d && (match_cnt_q != {CNT_W{1'b1}})) begin
                match_cnt_d = match_cnt_q + CNT_W'(1);
            end
            if (fail_d && (fail_cnt_q != {CNT_W{1'b1}})) begin
                fail_cnt_d = fail_cnt_q + CNT_W'(1);
            end
        end
    end

    // FSM and registered outputs
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            step_q      <= '0;
            gap_q       <= '0;
            len_q       <= '0;
            sel_q       <= '0;
            match_q     <= 1'b0;
            fail_q      <= 1'b0;
            match_cnt_q <= '0;
            fail_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            gap_q       <= gap_d;
            len_q       <= len_d;
            sel_q       <= sel_d;
            match_q     <= match_d;
            fail_q      <= fail_d;
            match_cnt_q <= match_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
        end
    end

    assign match     = match_q;
    assign fail      = fail_q;
    assign busy      = (state_q == ARMED);
    assign cur_step  = step_q;
    assign match_cnt = match_cnt_q;
    assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_seq_order_monitor.sv
// Bench for seq_order_monitor: a per-cycle vector table for the default configuration,
// then short hand-written sequences for gap window, strict mode and counter saturation.
module tb_seq_order_monitor;

    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    logic        sysclk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        clear;
    logic [2:0]  cfg_len;
    logic [17:0] cfg_step_ev;
    logic [5:0]  ev0, ev1, ev2, ev3;

    logic        m0, f0, b0, m1, f1, b1, m2, f2, b2, m3, f3, b3;
    logic [2:0]  s0, s1, s2, s3;
    logic [15:0] mc0, fc0, mc1, fc1, mc2, fc2;
    logic [1:0]  mc3, fc3;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [5:0] ev;
        logic       en;
        logic       clr;
        logic [2:0] len;
        logic       m, f, b;
        logic [2:0] s;
        int         mc, fc;
    } vec_t;

    typedef struct {
        int         dut;
        logic       m, f, b;
        logic [2:0] s;
        int         mc, fc;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];

    always #5 sysclk = ~sysclk;

    seq_order_monitor u_dut (
        .sysclk(sysclk), .rst_n(rst_n), .enable(enable), .clear(clear), .ev(ev0),
        .cfg_len(cfg_len), .cfg_step_ev(cfg_step_ev), .match(m0), .fail(f0), .busy(b0),
        .cur_step(s0), .match_cnt(mc0), .fail_cnt(fc0));

    seq_order_monitor #(.MAX_GAP(3)) u_gap (
        .sysclk(sysclk), .rst_n(rst_n), .enable(enable), .clear(clear), .ev(ev1),
        .cfg_len(cfg_len), .cfg_step_ev(cfg_step_ev), .match(m1), .fail(f1), .busy(b1),
        .cur_step(s1), .match_cnt(mc1), .fail_cnt(fc1));

    seq_order_monitor #(.MAX_GAP(3), .STRICT(1)) u_strict (
        .sysclk(sysclk), .rst_n(rst_n), .enable(enable), .clear(clear), .ev(ev2),
        .cfg_len(cfg_len), .cfg_step_ev(cfg_step_ev), .match(m2), .fail(f2), .busy(b2),
        .cur_step(s2), .match_cnt(mc2), .fail_cnt(fc2));

    seq_order_monitor #(.CNT_W(2)) u_cnt (
        .sysclk(sysclk), .rst_n(rst_n), .enable(enable), .clear(clear), .ev(ev3),
        .cfg_len(cfg_len), .cfg_step_ev(cfg_step_ev), .match(m3), .fail(f3), .busy(b3),
        .cur_step(s3), .match_cnt(mc3), .fail_cnt(fc3));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic compare_dut(input string tag, input int dut, input logic xm, input logic xf,
                               input logic xb, input logic [2:0] xs, input int xmc, input int xfc);
        logic [31:0] am, af, ab, as_, amc, afc;
        case (dut)
            0:       begin am = 32'(m0); af = 32'(f0); ab = 32'(b0); as_ = 32'(s0); amc = 32'(mc0); afc = 32'(fc0); end
            1:       begin am = 32'(m1); af = 32'(f1); ab = 32'(b1); as_ = 32'(s1); amc = 32'(mc1); afc = 32'(fc1); end
            2:       begin am = 32'(m2); af = 32'(f2); ab = 32'(b2); as_ = 32'(s2); amc = 32'(mc2); afc = 32'(fc2); end
            default: begin am = 32'(m3); af = 32'(f3); ab = 32'(b3); as_ = 32'(s3); amc = 32'(mc3); afc = 32'(fc3); end
        endcase
        check($sformatf("%s.match", tag),     am,  32'(xm));
        check($sformatf("%s.fail", tag),      af,  32'(xf));
        check($sformatf("%s.busy", tag),      ab,  32'(xb));
        check($sformatf("%s.cur_step", tag),  as_, 32'(xs));
        check($sformatf("%s.match_cnt", tag), amc, 32'(xmc));
        check($sformatf("%s.fail_cnt", tag),  afc, 32'(xfc));
    endtask

    // Drive one cycle of stimulus to one instance, queue its expectation, compare after the edge
    task automatic cycle(input string tag, input int dut, input logic [5:0] e, input logic en,
                         input logic clr, input logic [2:0] len, input logic xm, input logic xf,
                         input logic xb, input logic [2:0] xs, input int xmc, input int xfc);
        exp_t x;
        @(negedge sysclk);
        ev0     = (dut == 0) ? e : 6'd0;
        ev1     = (dut == 1) ? e : 6'd0;
        ev2     = (dut == 2) ? e : 6'd0;
        ev3     = (dut == 3) ? e : 6'd0;
        enable  = en;
        clear   = clr;
        cfg_len = len;
        x.dut = dut; x.m = xm; x.f = xf; x.b = xb; x.s = xs; x.mc = xmc; x.fc = xfc;
        exp_q.push_back(x);
        @(posedge sysclk);
        #1;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            x = exp_q.pop_front();
            compare_dut(tag, x.dut, x.m, x.f, x.b, x.s, x.mc, x.fc);
        end
    endtask

    function automatic void add(input logic [5:0] e, input logic en, input logic clr,
                                input logic [2:0] len, input logic xm, input logic xf,
                                input logic xb, input logic [2:0] xs, input int xmc, input int xfc);
        vec_t v;
        v.ev = e; v.en = en; v.clr = clr; v.len = len;
        v.m = xm; v.f = xf; v.b = xb; v.s = xs; v.mc = xmc; v.fc = xfc;
        tbl.push_back(v);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b1;
        enable      = 1'b0;
        clear       = 1'b0;
        cfg_len     = 3'd6;
        cfg_step_ev = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        ev0 = '0; ev1 = '0; ev2 = '0; ev3 = '0;
        #2 rst_n = 1'b0;
        #1;
        compare_dut("reset", 0, N, N, N, 3'd0, 0, 0);
        compare_dut("reset_cnt", 3, N, N, N, 3'd0, 0, 0);
        @(negedge sysclk);
        @(negedge sysclk);
        rst_n  = 1'b1;
        enable = 1'b1;

        //  ev      en clr len     m  f  b  step  mc fc
        add(6'h01, Y, N, 3'd6,   N, N, Y, 3'd1, 0, 0);  // full ##1 chain
        add(6'h02, Y, N, 3'd6,   N, N, Y, 3'd2, 0, 0);
        add(6'h04, Y, N, 3'd6,   N, N, Y, 3'd3, 0, 0);
        add(6'h08, Y, N, 3'd6,   N, N, Y, 3'd4, 0, 0);
        add(6'h10, Y, N, 3'd6,   N, N, Y, 3'd5, 0, 0);
        add(6'h20, Y, N, 3'd6,   Y, N, N, 3'd0, 1, 0);
        add(6'h00, Y, N, 3'd6,   N, N, N, 3'd0, 1, 0);
        add(6'h01, Y, N, 3'd6,   N, N, Y, 3'd1, 1, 0);  // idle cycle after ev[2]
        add(6'h02, Y, N, 3'd6,   N, N, Y, 3'd2, 1, 0);
        add(6'h04, Y, N, 3'd6,   N, N, Y, 3'd3, 1, 0);
        add(6'h00, Y, N, 3'd6,   N, Y, N, 3'd0, 1, 1);
        add(6'h00, Y, N, 3'd6,   N, N, N, 3'd0, 1, 1);
        add(6'h01, Y, N, 3'd6,   N, N, Y, 3'd1, 1, 1);  // fail cycle with ev[0] does not restart
        add(6'h02, Y, N, 3'd6,   N, N, Y, 3'd2, 1, 1);
        add(6'h01, Y, N, 3'd6,   N, Y, N, 3'd0, 1, 2);
        add(6'h01, Y, N, 3'd6,   N, N, Y, 3'd1, 1, 2);
        add(6'h02, Y, N, 3'd6,   N, N, Y, 3'd2, 1, 2);
        add(6'h04, Y, N, 3'd6,   N, N, Y, 3'd3, 1, 2);
        add(6'h08, Y, N, 3'd6,   N, N, Y, 3'd4, 1, 2);
        add(6'h10, N, N, 3'd6,   N, N, N, 3'd0, 1, 2);  // enable dropped at step 4
        add(6'h01, N, N, 3'd6,   N, N, N, 3'd0, 1, 2);
        add(6'h01, Y, N, 3'd6,   N, N, Y, 3'd1, 1, 2);  // match cycle with ev[0] does not restart
        add(6'h02, Y, N, 3'd6,   N, N, Y, 3'd2, 1, 2);
        add(6'h04, Y, N, 3'd6,   N, N, Y, 3'd3, 1, 2);
        add(6'h08, Y, N, 3'd6,   N, N, Y, 3'd4, 1, 2);
        add(6'h10, Y, N, 3'd6,   N, N, Y, 3'd5, 1, 2);
        add(6'h21, Y, N, 3'd6,   Y, N, N, 3'd0, 2, 2);
        add(6'h00, Y, N, 3'd6,   N, N, N, 3'd0, 2, 2);
        add(6'h00, Y, Y, 3'd6,   N, N, N, 3'd0, 0, 0);  // clear
        add(6'h00, Y, N, 3'd6,   N, N, N, 3'd0, 0, 0);
        add(6'h01, Y, N, 3'd1,   Y, N, N, 3'd0, 1, 0);  // L=1 matches from IDLE
        add(6'h01, Y, N, 3'd1,   Y, N, N, 3'd0, 2, 0);
        add(6'h00, Y, N, 3'd1,   N, N, N, 3'd0, 2, 0);
        add(6'h01, Y, N, 3'd6,   N, N, Y, 3'd1, 2, 0);  // cfg_len change while ARMED ignored
        add(6'h02, Y, N, 3'd2,   N, N, Y, 3'd2, 2, 0);
        add(6'h04, Y, N, 3'd2,   N, N, Y, 3'd3, 2, 0);
        add(6'h00, Y, N, 3'd6,   N, Y, N, 3'd0, 2, 1);
        add(6'h01, Y, N, 3'd0,   N, N, N, 3'd0, 2, 1);  // L=0 disables detection
        add(6'h01, Y, N, 3'd7,   N, N, Y, 3'd1, 2, 1);  // L>DEPTH clamps to DEPTH
        add(6'h02, Y, N, 3'd6,   N, N, Y, 3'd2, 2, 1);
        add(6'h04, Y, N, 3'd6,   N, N, Y, 3'd3, 2, 1);
        add(6'h08, Y, N, 3'd6,   N, N, Y, 3'd4, 2, 1);
        add(6'h10, Y, N, 3'd6,   N, N, Y, 3'd5, 2, 1);
        add(6'h20, Y, N, 3'd6,   Y, N, N, 3'd0, 3, 1);
        add(6'h00, Y, N, 3'd6,   N, N, N, 3'd0, 3, 1);

        foreach (tbl[i]) begin
            cycle($sformatf("vec%0d", i), 0, tbl[i].ev, tbl[i].en, tbl[i].clr, tbl[i].len,
                  tbl[i].m, tbl[i].f, tbl[i].b, tbl[i].s, tbl[i].mc, tbl[i].fc);
        end

        // async reset mid-attempt
        cycle("rst_pre0", 0, 6'h01, Y, N, 3'd6, N, N, Y, 3'd1, 3, 1);
        cycle("rst_pre1", 0, 6'h02, Y, N, 3'd6, N, N, Y, 3'd2, 3, 1);
        cycle("rst_pre2", 0, 6'h04, Y, N, 3'd6, N, N, Y, 3'd3, 3, 1);
        cycle("rst_pre3", 0, 6'h08, Y, N, 3'd6, N, N, Y, 3'd4, 3, 1);
        #2 rst_n = 1'b0;
        #1;
        compare_dut("rst_mid", 0, N, N, N, 3'd0, 0, 0);
        @(negedge sysclk);
        ev0   = '0;
        rst_n = 1'b1;

        // MAX_GAP=3: two idle cycles between steps still match
        for (int s = 0; s < 6; s++) begin
            cycle($sformatf("gap_step%0d", s), 1, 6'(1 << s), Y, N, 3'd6,
                  (s == 5), N, (s != 5), (s == 5) ? 3'd0 : 3'(s + 1), (s == 5) ? 1 : 0, 0);
            if (s < 5) begin
                for (int g = 0; g < 2; g++) begin
                    cycle($sformatf("gap_idle%0d_%0d", s, g), 1, 6'h00, Y, N, 3'd6,
                          N, N, Y, 3'(s + 1), 0, 0);
                end
            end
        end
        cycle("gap_after", 1, 6'h00, Y, N, 3'd6, N, N, N, 3'd0, 1, 0);
        // three idle cycles time out
        cycle("gto_start", 1, 6'h01, Y, N, 3'd6, N, N, Y, 3'd1, 1, 0);
        cycle("gto_idle1", 1, 6'h00, Y, N, 3'd6, N, N, Y, 3'd1, 1, 0);
        cycle("gto_idle2", 1, 6'h00, Y, N, 3'd6, N, N, Y, 3'd1, 1, 0);
        cycle("gto_idle3", 1, 6'h00, Y, N, 3'd6, N, Y, N, 3'd0, 1, 1);
        cycle("gto_after", 1, 6'h00, Y, N, 3'd6, N, N, N, 3'd0, 1, 1);

        // STRICT=1: ev[3] while waiting for step 2 aborts
        cycle("str_s0", 2, 6'h01, Y, N, 3'd6, N, N, Y, 3'd1, 0, 0);
        cycle("str_s1", 2, 6'h02, Y, N, 3'd6, N, N, Y, 3'd2, 0, 0);
        cycle("str_bad", 2, 6'h08, Y, N, 3'd6, N, Y, N, 3'd0, 0, 1);
        cycle("str_after", 2, 6'h00, Y, N, 3'd6, N, N, N, 3'd0, 0, 1);
        // STRICT=0, same stimulus: attempt continues to a match
        cycle("lax_s0", 1, 6'h01, Y, N, 3'd6, N, N, Y, 3'd1, 1, 1);
        cycle("lax_s1", 1, 6'h02, Y, N, 3'd6, N, N, Y, 3'd2, 1, 1);
        cycle("lax_bad", 1, 6'h08, Y, N, 3'd6, N, N, Y, 3'd2, 1, 1);
        cycle("lax_s2", 1, 6'h04, Y, N, 3'd6, N, N, Y, 3'd3, 1, 1);
        cycle("lax_s3", 1, 6'h08, Y, N, 3'd6, N, N, Y, 3'd4, 1, 1);
        cycle("lax_s4", 1, 6'h10, Y, N, 3'd6, N, N, Y, 3'd5, 1, 1);
        cycle("lax_s5", 1, 6'h20, Y, N, 3'd6, Y, N, N, 3'd0, 2, 1);
        // expected event wins over a simultaneous out-of-order event
        cycle("pri_s0", 2, 6'h01, Y, N, 3'd6, N, N, Y, 3'd1, 0, 1);
        cycle("pri_s1", 2, 6'h0A, Y, N, 3'd6, N, N, Y, 3'd2, 0, 1);
        cycle("pri_s2", 2, 6'h05, Y, N, 3'd6, N, N, Y, 3'd3, 0, 1);
        cycle("pri_bad", 2, 6'h20, Y, N, 3'd6, N, Y, N, 3'd0, 0, 2);

        // CNT_W=2: counter saturates at 3; clear beats a simultaneous match
        for (int i = 0; i < 5; i++) begin
            cycle($sformatf("sat%0d", i), 3, 6'h01, Y, N, 3'd1, Y, N, N, 3'd0,
                  (i < 3) ? i + 1 : 3, 0);
        end
        cycle("sat_clear", 3, 6'h01, Y, Y, 3'd1, Y, N, N, 3'd0, 0, 0);
        cycle("sat_after", 3, 6'h00, Y, N, 3'd6, N, N, N, 3'd0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
